uart_sync_fifo: RTL and testbench

// - Parametrised single-clock show-ahead FIFO in inferred RAM; next generation of the UART byte FIFO.
// - Buffers UART RX/TX data between uart_rx/uart_tx and the command parser; vendor-neutral, no scfifo.
// - Adds: configurable width/depth, fill count, almost-full/almost-empty thresholds, synchronous flush.

---
 rtl/uart_sync_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_sync_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO over an inferred RAM with fill count, thresholds and flush.
// Optional sticky overflow/underflow flags are enabled with `define UART_SYNC_FIFO_ERR_FLAGS_EN.
module uart_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned AFULL_LVL  = 192,
  parameter int unsigned AEMPTY_LVL = 16,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_write,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_read,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_afull,
  output logic             o_aempty,
  output logic [AW:0]      o_used
`ifdef UART_SYNC_FIFO_ERR_FLAGS_EN
  ,
  input  logic             i_clr_err,
  output logic             o_overflow,
  output logic             o_underflow
`endif
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_IN   = 2'd1,
    SEL_MEM  = 2'd2
  } data_sel_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_used;
  logic [WIDTH-1:0] r_data;
  logic             r_empty;
  logic             r_full;
  logic             r_afull;
  logic             r_aempty;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [AW-1:0]    w_wr_ptr_nxt;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [AW-1:0]    w_rd_ptr_inc;
  logic [CW-1:0]    w_used_nxt;
  data_sel_e        w_data_sel;

  assign w_wr_acc     = i_write & (~r_full | i_read);
  assign w_rd_acc     = i_read & ~r_empty;
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

  // Next pointers, count and head-register source
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_used_nxt   = r_used;
    w_data_sel   = SEL_HOLD;
    if (i_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_used_nxt   = '0;
    end else begin
      if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      if (w_rd_acc) w_rd_ptr_nxt = w_rd_ptr_inc;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_used_nxt = r_used + CW'(1);
        2'b01:   w_used_nxt = r_used - CW'(1);
        default: w_used_nxt = r_used;
      endcase
      // The new word becomes head when nothing else would be left to show
      if (w_wr_acc && (r_empty || (w_rd_acc && r_used == CW'(1)))) begin
        w_data_sel = SEL_IN;
      end else if (w_rd_acc && r_used != CW'(1)) begin
        w_data_sel = SEL_MEM;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_acc && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
      r_data   <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_used   <= w_used_nxt;
      r_empty  <= (w_used_nxt == '0);
      r_full   <= (w_used_nxt == CW'(DEPTH));
      r_afull  <= (w_used_nxt >= CW'(AFULL_LVL));
      r_aempty <= (w_used_nxt <= CW'(AEMPTY_LVL));
      case (w_data_sel)
        SEL_IN:  r_data <= i_data;
        SEL_MEM: r_data <= r_mem[w_rd_ptr_inc];
        default: r_data <= r_data;
      endcase
    end
  end

  assign o_data   = r_data;
  assign o_empty  = r_empty;
  assign o_full   = r_full;
  assign o_afull  = r_afull;
  assign o_aempty = r_aempty;
  assign o_used   = r_used;

`ifdef UART_SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_set;
  logic w_udf_set;
  logic w_err_clr;

  assign w_ovf_set = i_write & r_full & ~i_read;
  assign w_udf_set = i_read & r_empty;
  assign w_err_clr = i_clr_err | i_flush;

  // Sticky error flags; a new event outranks a clear in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (w_err_clr) r_overflow <= 1'b0;
      if (w_udf_set)      r_underflow <= 1'b1;
      else if (w_err_clr) r_underflow <= 1'b0;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`endif

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Scoreboard bench for uart_sync_fifo: reference queue tracks contents, head word and flags.
module tb_uart_sync_fifo;

  localparam int DEPTH      = 256;
  localparam int AFULL_LVL  = 192;
  localparam int AEMPTY_LVL = 16;

  logic       clk;
  logic       rst_n;
  logic       i_flush;
  logic [7:0] i_data;
  logic       i_write;
  logic [7:0] o_data;
  logic       i_read;
  logic       o_empty;
  logic       o_full;
  logic       o_afull;
  logic       o_aempty;
  logic [8:0] o_used;
  logic       i_clr_err;
  logic       o_overflow;
  logic       o_underflow;

  int n_chk;
  int n_fail;

  logic [7:0] q[$];
  logic [7:0] m_data;
  logic       m_ovf;
  logic       m_udf;

  uart_sync_fifo dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_flush    (i_flush),
    .i_data     (i_data),
    .i_write    (i_write),
    .o_data     (o_data),
    .i_read     (i_read),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_afull    (o_afull),
    .o_aempty   (o_aempty),
    .o_used     (o_used)
`ifdef UART_SYNC_FIFO_ERR_FLAGS_EN
    ,
    .i_clr_err  (i_clr_err),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow)
`endif
  );

`ifndef UART_SYNC_FIFO_ERR_FLAGS_EN
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    check("used",   32'(o_used),   32'(n));
    check("empty",  32'(o_empty),  32'(n == 0));
    check("full",   32'(o_full),   32'(n == DEPTH));
    check("afull",  32'(o_afull),  32'(n >= AFULL_LVL));
    check("aempty", 32'(o_aempty), 32'(n <= AEMPTY_LVL));
    check("data",   32'(o_data),   32'(m_data));
`ifdef UART_SYNC_FIFO_ERR_FLAGS_EN
    check("overflow",  32'(o_overflow),  32'(m_ovf));
    check("underflow", 32'(o_underflow), 32'(m_udf));
`endif
  endtask

  // One clock of stimulus; called #1 after a rising edge
  task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                       input logic f, input logic c);
    logic       wa;
    logic       ra;
    logic [7:0] exp;
    i_write   = w;
    i_data    = d;
    i_read    = r;
    i_flush   = f;
    i_clr_err = c;
    wa = w && (q.size() < DEPTH || r);
    ra = r && q.size() > 0;
    if (w && q.size() == DEPTH && !r) m_ovf = 1'b1;
    else if (c || f)                  m_ovf = 1'b0;
    if (r && q.size() == 0)           m_udf = 1'b1;
    else if (c || f)                  m_udf = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      if (ra) begin
        exp = q.pop_front();
        check("sb_head", 32'(o_data), 32'(exp));
      end
      if (wa) q.push_back(d);
    end
    if (q.size() > 0) m_data = q[0];
    @(posedge clk);
    #1;
    i_write   = 1'b0;
    i_read    = 1'b0;
    i_flush   = 1'b0;
    i_clr_err = 1'b0;
    check_state();
  endtask

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    i_write = 1'b0;
    i_read = 1'b0;
    i_flush = 1'b0;
    i_clr_err = 1'b0;
    i_data = '0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_state();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Show-ahead write, then drain leaving a stale head
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("show_ahead", 32'(o_data), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Single word with simultaneous read and write
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    check("rw_at_one", 32'(o_data), 32'h5A);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset while holding 5 words
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 8'h40), 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_used",  32'(o_used),  32'd0);
    check("rst_full",  32'(o_full),  32'd0);
    check_state();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, read+write while full, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check("fill_full", 32'(o_full), 32'd1);
    check("fill_used", 32'(o_used), 32'd256);
    cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    check("rw_full_used", 32'(o_used), 32'd256);
    check("rw_full_flag", 32'(o_full), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("drain_last", 32'(o_data), 32'h3C);
    check("drain_empty", 32'(o_empty), 32'd1);

    // Thresholds
    for (int i = 0; i < AFULL_LVL - 1; i++) cycle(1'b1, 8'(i ^ 8'h55), 1'b0, 1'b0, 1'b0);
    check("afull_below", 32'(o_afull), 32'd0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("afull_at", 32'(o_afull), 32'd1);
    for (int i = 0; i < AFULL_LVL - AEMPTY_LVL - 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("aempty_above", 32'(o_aempty), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("aempty_at", 32'(o_aempty), 32'd1);

    // Flush with a competing write; head word is retained
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    check("flush_used", 32'(o_used), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    check("flush10_used", 32'(o_used), 32'd0);

    // Overflow, underflow and their clear
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i * 3), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef UART_SYNC_FIFO_ERR_FLAGS_EN
    check("ovf_set", 32'(o_overflow),  32'd1);
    check("udf_set", 32'(o_underflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(o_overflow),  32'd0);
    check("udf_clr", 32'(o_underflow), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("udf_set_wins", 32'(o_underflow), 32'd1);
`endif

    // Random traffic mix
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
